// File: rtl/uart_alu_top.sv
// uart_alu_top: iCEBreaker UART ALU -- PLL, 8N1 UART RX/TX and packet engine (echo/add32/xor32).
// Macros: UART_ALU_MUL_EN adds opcode 0x88 (mul32); ICE40_PLL selects the SB_PLL40_PAD primitive.

module uart_alu_pll (
   input  logic PACKAGEPIN,
   output logic PLLOUTGLOBAL
);
`ifdef ICE40_PLL
   // 12 MHz * 67 / 16 = 50.25 MHz core clock
   SB_PLL40_PAD #(
      .FEEDBACK_PATH("SIMPLE"), .DIVR(4'd0), .DIVF(7'd66), .DIVQ(3'd4), .FILTER_RANGE(3'd1)
   ) u_pll (
      .PACKAGEPIN(PACKAGEPIN), .PLLOUTCORE(), .PLLOUTGLOBAL(PLLOUTGLOBAL),
      .RESETB(1'b1), .BYPASS(1'b0), .LOCK()
   );
`else
   assign PLLOUTGLOBAL = PACKAGEPIN;
`endif
endmodule

module uart_alu_top #(
   parameter int PRESCALE_P   = 1,
   parameter int DATA_WIDTH_P = 8
) (
   input  logic CLK,
   input  logic BTN_N,
   input  logic RX,
   output logic TX
);
   localparam int BT = 8 * PRESCALE_P;
   localparam int CW = $clog2(BT);
   localparam int BW = $clog2(DATA_WIDTH_P);
   localparam logic [7:0] OP_ECHO = 8'hEC, OP_ADD = 8'hA0, OP_XOR = 8'hB0;

   logic       w_clk, w_rst_n;
   logic [1:0] r_rst_sync;

   uart_alu_pll pll (.PACKAGEPIN(CLK), .PLLOUTGLOBAL(w_clk));

   always_ff @(posedge w_clk or negedge BTN_N)
      if (!BTN_N) r_rst_sync <= '0;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   assign w_rst_n = r_rst_sync[1];

   // ---------------- UART RX ----------------
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_st_t;
   rx_st_t                  r_rx_st, w_rx_nxt;
   logic [1:0]              r_rx_s;
   logic [CW-1:0]           r_rx_cnt;
   logic [BW-1:0]           r_rx_bit;
   logic [DATA_WIDTH_P-1:0] r_rx_sh, r_rx_data;
   logic                    r_rx_vld, w_rx_tick, w_rx_in, w_pk_rdy, w_rx_fire;

   assign w_rx_in   = r_rx_s[1];
   assign w_rx_tick = (r_rx_cnt == '0);
   assign w_rx_fire = r_rx_vld & w_pk_rdy;

   // A low stop bit parks in RX_BRK until the line returns high, so a break is not re-read as a start
   always_comb begin
      w_rx_nxt = r_rx_st;
      case (r_rx_st)
         RX_IDLE:  if (!w_rx_in) w_rx_nxt = RX_START;
         RX_START: if (w_rx_tick) w_rx_nxt = w_rx_in ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == BW'(DATA_WIDTH_P - 1)) w_rx_nxt = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_nxt = w_rx_in ? RX_IDLE : RX_BRK;
         RX_BRK:   if (w_rx_in) w_rx_nxt = RX_IDLE;
         default:  w_rx_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_rx_st   <= RX_IDLE;
         r_rx_s    <= '1;
         r_rx_cnt  <= '0;
         r_rx_bit  <= '0;
         r_rx_sh   <= '0;
         r_rx_data <= '0;
         r_rx_vld  <= 1'b0;
      end else begin
         r_rx_st <= w_rx_nxt;
         r_rx_s  <= {r_rx_s[0], RX};
         if (w_rx_fire) r_rx_vld <= 1'b0;
         if (r_rx_st == RX_IDLE || r_rx_st == RX_BRK) begin
            r_rx_cnt <= CW'(BT / 2 - 1);
            r_rx_bit <= '0;
         end else if (w_rx_tick) begin
            r_rx_cnt <= CW'(BT - 1);
            if (r_rx_st == RX_DATA) begin
               r_rx_sh  <= {w_rx_in, r_rx_sh[DATA_WIDTH_P-1:1]};
               r_rx_bit <= r_rx_bit + 1'b1;
            end
            if (r_rx_st == RX_STOP && w_rx_in) begin
               r_rx_data <= r_rx_sh;
               r_rx_vld  <= 1'b1;
            end
         end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
         end
      end

   // ---------------- TX FIFO (4 entries) ----------------
   logic [DATA_WIDTH_P-1:0] r_fifo [4];
   logic [2:0]              r_wp, r_rp;
   logic                    w_full, w_empty, w_push, w_pop;
   logic [DATA_WIDTH_P-1:0] w_push_data;

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp == {~r_rp[2], r_rp[1:0]});

   always_ff @(posedge w_clk)
      if (w_push) r_fifo[r_wp[1:0]] <= w_push_data;

   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
      end

   // ---------------- UART TX ----------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;
   tx_st_t                  r_tx_st, w_tx_nxt;
   logic [CW-1:0]           r_tx_cnt;
   logic [BW-1:0]           r_tx_bit;
   logic [DATA_WIDTH_P-1:0] r_tx_sh;
   logic                    r_tx, w_tx_tick, w_tx_last;

   assign w_tx_tick = (r_tx_cnt == '0);
   assign w_tx_last = (r_tx_bit == BW'(DATA_WIDTH_P - 1));
   assign w_pop     = (r_tx_st == TX_IDLE) && !w_empty;
   assign TX        = r_tx;

   always_comb begin
      w_tx_nxt = r_tx_st;
      case (r_tx_st)
         TX_IDLE:  if (!w_empty) w_tx_nxt = TX_START;
         TX_START: if (w_tx_tick) w_tx_nxt = TX_DATA;
         TX_DATA:  if (w_tx_tick && w_tx_last) w_tx_nxt = TX_STOP;
         TX_STOP:  if (w_tx_tick) w_tx_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_tx_st  <= TX_IDLE;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         r_tx_sh  <= '0;
         r_tx     <= 1'b1;
      end else begin
         r_tx_st <= w_tx_nxt;
         if (r_tx_st == TX_IDLE) begin
            r_tx_cnt <= CW'(BT - 1);
            r_tx_bit <= '0;
            if (!w_empty) begin
               r_tx_sh <= r_fifo[r_rp[1:0]];
               r_tx    <= 1'b0;
            end
         end else if (w_tx_tick) begin
            r_tx_cnt <= CW'(BT - 1);
            if (r_tx_st == TX_START || (r_tx_st == TX_DATA && !w_tx_last)) begin
               r_tx    <= r_tx_sh[0];
               r_tx_sh <= {1'b0, r_tx_sh[DATA_WIDTH_P-1:1]};
               if (r_tx_st == TX_DATA) r_tx_bit <= r_tx_bit + 1'b1;
            end else begin
               r_tx <= 1'b1;
            end
         end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
         end
      end

   // ---------------- Packet engine ----------------
   typedef enum logic [2:0] {P_IDLE, P_HDR1, P_LENL, P_LENH, P_PAYLOAD, P_RESP} pk_st_t;
   pk_st_t      r_pk_st, w_pk_nxt;
   logic [7:0]  r_op, w_byte;
   logic [15:0] r_len, r_cnt, w_len_full;
   logic [31:0] r_acc, r_opnd, w_word, w_mul;
   logic [1:0]  r_bsel, r_ridx;
   logic        w_is_echo, w_is_arith, w_is_mul, w_last;

`ifdef UART_ALU_MUL_EN
   localparam logic [7:0] OP_MUL = 8'h88;
   assign w_is_mul = (r_op == OP_MUL);
   assign w_mul    = r_acc * w_word;
`else
   assign w_is_mul = 1'b0;
   assign w_mul    = r_acc;
`endif

   assign w_byte     = r_rx_data[7:0];
   assign w_is_echo  = (r_op == OP_ECHO);
   assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_XOR) || w_is_mul;
   assign w_word     = {w_byte, r_opnd[23:0]};
   assign w_len_full = {w_byte, r_len[7:0]};
   assign w_last     = (r_cnt + 16'd1 == r_len);

   // RESP only parks the result in the FIFO, so the next header is accepted while TX drains
   always_comb begin
      w_pk_nxt    = r_pk_st;
      w_pk_rdy    = 1'b1;
      w_push      = 1'b0;
      w_push_data = DATA_WIDTH_P'(w_byte);
      case (r_pk_st)
         P_IDLE: if (r_rx_vld) w_pk_nxt = P_HDR1;
         P_HDR1: if (r_rx_vld) w_pk_nxt = P_LENL;
         P_LENL: if (r_rx_vld) w_pk_nxt = P_LENH;
         P_LENH: if (r_rx_vld) w_pk_nxt = (w_len_full > 16'd4) ? P_PAYLOAD : P_IDLE;
         P_PAYLOAD: begin
            if (w_is_echo) begin
               w_pk_rdy = !w_full;
               w_push   = r_rx_vld && !w_full;
            end
            if (r_rx_vld && w_pk_rdy && w_last) w_pk_nxt = w_is_arith ? P_RESP : P_IDLE;
         end
         P_RESP: begin
            w_pk_rdy    = 1'b0;
            w_push      = !w_full;
            w_push_data = DATA_WIDTH_P'(r_acc[8*r_ridx +: 8]);
            if (!w_full && r_ridx == 2'd3) w_pk_nxt = P_IDLE;
         end
         default: w_pk_nxt = P_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_pk_st <= P_IDLE;
         r_op    <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_bsel  <= '0;
         r_ridx  <= '0;
      end else begin
         r_pk_st <= w_pk_nxt;
         if (w_rx_fire) begin
            r_cnt <= r_cnt + 16'd1;
            case (r_pk_st)
               P_IDLE: begin
                  r_op  <= w_byte;
                  r_cnt <= 16'd1;
               end
               P_LENL: r_len[7:0] <= w_byte;
               P_LENH: begin
                  r_len[15:8] <= w_byte;
                  r_acc       <= w_is_mul ? 32'd1 : 32'd0;
                  r_bsel      <= '0;
                  r_ridx      <= '0;
               end
               P_PAYLOAD: begin
                  r_opnd[8*r_bsel +: 8] <= w_byte;
                  r_bsel                <= r_bsel + 1'b1;
                  if (r_bsel == 2'd3)
                     r_acc <= (r_op == OP_ADD) ? r_acc + w_word :
                              (r_op == OP_XOR) ? r_acc ^ w_word : w_mul;
               end
               default: ;
            endcase
         end
         if (r_pk_st == P_RESP && !w_full) r_ridx <= r_ridx + 1'b1;
      end

endmodule

// File: tb/tb_uart_alu_top.sv
// Randomized scoreboard bench for uart_alu_top: packets are modelled arithmetically, a TX monitor pops and compares.
module tb_uart_alu_top;
   localparam int PRESC = 1;
   localparam int BT    = 8 * PRESC;
`ifdef UART_ALU_MUL_EN
   localparam bit MUL = 1'b1;
`else
   localparam bit MUL = 1'b0;
`endif

   logic CLK = 1'b0;
   logic BTN_N = 1'b0;
   logic RX = 1'b1;
   logic TX;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] pay_q[$];

   uart_alu_top #(.PRESCALE_P(PRESC), .DATA_WIDTH_P(8)) dut (
      .CLK(CLK), .BTN_N(BTN_N), .RX(RX), .TX(TX)
   );

   always #10 CLK = ~CLK;

   initial begin : watchdog
      repeat (95000) @(posedge CLK);
      $display("FAIL watchdog cycle budget exhausted, pending %0d expected 0", exp_q.size());
      $fatal(1, "timeout");
   end

   // TX monitor: decodes each 8N1 frame and checks it against the scoreboard head
   initial begin : monitor
      logic [7:0] b;
      logic [7:0] e;
      logic       stop_bit;
      forever begin
         @(negedge CLK);
         if (BTN_N && TX === 1'b0) begin
            repeat (BT / 2) @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
               repeat (BT) @(negedge CLK);
               b[i] = TX;
            end
            repeat (BT) @(negedge CLK);
            stop_bit = TX;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected got %02h expected no byte", b);
            end else begin
               e = exp_q.pop_front();
               if (b !== e || stop_bit !== 1'b1) begin
                  errors++;
                  $display("FAIL tx_byte got %02h stop %0b expected %02h stop 1", b, stop_bit, e);
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      RX = 1'b0;
      repeat (BT) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (BT) @(negedge CLK);
      end
      RX = !bad_stop;
      repeat (BT) @(negedge CLK);
      if (bad_stop) begin
         RX = 1'b1;
         repeat (BT) @(negedge CLK);
      end
   endtask

   // Reference model: the expected response is derived from the packet contents, then the packet is sent
   task automatic send_pkt(input logic [7:0] op, input logic [7:0] rsv, input logic [15:0] len);
      int n;
      logic [31:0] acc, w;
      n = (len > 16'd4) ? int'(len) - 4 : 0;
      if (n > 0) begin
         if (op == 8'hEC) begin
            foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
         end else if (op == 8'hA0 || op == 8'hB0 || (MUL && op == 8'h88)) begin
            acc = (op == 8'h88) ? 32'd1 : 32'd0;
            for (int k = 0; k < n / 4; k++) begin
               w = {pay_q[4*k+3], pay_q[4*k+2], pay_q[4*k+1], pay_q[4*k]};
               if (op == 8'hA0)      acc = acc + w;
               else if (op == 8'hB0) acc = acc ^ w;
               else                  acc = acc * w;
            end
            for (int j = 0; j < 4; j++) exp_q.push_back(acc[8*j +: 8]);
         end
      end
      send_byte(op, 1'b0);
      send_byte(rsv, 1'b0);
      send_byte(len[7:0], 1'b0);
      send_byte(len[15:8], 1'b0);
      foreach (pay_q[i]) send_byte(pay_q[i], 1'b0);
   endtask

   task automatic set_pay4(input logic [31:0] a, input logic [31:0] b, input int nwords);
      pay_q.delete();
      for (int j = 0; j < 4 && nwords > 0; j++) pay_q.push_back(a[8*j +: 8]);
      for (int j = 0; j < 4 && nwords > 1; j++) pay_q.push_back(b[8*j +: 8]);
   endtask

   task automatic wait_drain(input string tag);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(negedge CLK);
         t++;
      end
      repeat (12 * BT) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_%s pending %0d expected 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin : stim
      logic tx_hi;
      logic [7:0] op;
      logic [15:0] len;

      // Reset: TX idle high during and after reset
      tx_hi = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         tx_hi &= TX;
      end
      checks++;
      if (tx_hi !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", TX); end
      BTN_N = 1'b1;
      tx_hi = 1'b1;
      repeat (50) begin
         @(negedge CLK);
         tx_hi &= TX;
      end
      checks++;
      if (tx_hi !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %b expected 1", tx_hi); end

      // Echo
      pay_q = '{8'h41, 8'h42, 8'h43};
      send_pkt(8'hEC, 8'h00, 16'd7);
      wait_drain("echo");

      // Add32 wrap-around
      set_pay4(32'h0000_0001, 32'hFFFF_FFFF, 2);
      send_pkt(8'hA0, 8'h00, 16'd12);
      wait_drain("add_wrap");

      // Xor32 then add32 back-to-back
      set_pay4(32'h0000_00F0, 32'h0000_000F, 2);
      send_pkt(8'hB0, 8'h00, 16'd12);
      set_pay4(32'h0000_0005, 32'h0, 1);
      send_pkt(8'hA0, 8'h00, 16'd8);
      wait_drain("xor_add");

      // Unknown opcode then echo
      pay_q = '{8'h11, 8'h22};
      send_pkt(8'h77, 8'h00, 16'd6);
      pay_q = '{8'h5A};
      send_pkt(8'hEC, 8'h00, 16'd5);
      wait_drain("unknown");

      // Frame-error byte mid-echo is dropped and not counted
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      send_byte(8'hEC, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h41, 1'b0);
      send_byte(8'h99, 1'b1);
      send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b0);
      wait_drain("frame_err");

      // Zero operands, trailing partial operand, short LEN
      pay_q = '{8'h12, 8'h34, 8'h56};
      send_pkt(8'hA0, 8'h00, 16'd7);
      pay_q.delete();
      send_pkt(8'hB0, 8'h00, 16'd3);
      set_pay4(32'h0000_0003, 32'h0000_0005, 2);
      send_pkt(8'h88, 8'h00, 16'd12);
      wait_drain("edges");

      // Reset during 3rd payload byte of add32: nothing from it may appear
      send_byte(8'hA0, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h0C, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
      fork
         send_byte(8'h03, 1'b0);
         begin
            repeat (3 * BT) @(negedge CLK);
            BTN_N = 1'b0;
         end
      join
      repeat (2) @(negedge CLK);
      checks++;
      if (TX !== 1'b1) begin errors++; $display("FAIL midreset_tx got %b expected 1", TX); end
      repeat (5) @(negedge CLK);
      BTN_N = 1'b1;
      repeat (20) @(negedge CLK);
      pay_q = '{8'h5A};
      send_pkt(8'hEC, 8'h00, 16'd5);
      wait_drain("after_reset");

      // Randomized back-to-back packets
      for (int p = 0; p < 30; p++) begin
         case ($urandom_range(0, 5))
            0:       op = 8'hEC;
            1:       op = 8'hA0;
            2:       op = 8'hB0;
            3:       op = 8'h88;
            4:       op = 8'h77;
            default: op = 8'($urandom);
         endcase
         len = 16'($urandom_range(0, 18));
         pay_q.delete();
         for (int i = 4; i < int'(len); i++) pay_q.push_back(8'($urandom));
         send_pkt(op, 8'($urandom), len);
      end
      wait_drain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
